// File: rtl/dot_product_feeder_pkg.sv
// Shared types and size derivations for the dot-product feeder and its consumers.
package dot_product_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int beats_of(input int n, input int p);
    return (n + p - 1) / p;
  endfunction

  // Number of live lanes in the final beat; equals p when n divides evenly.
  function automatic int tail_of(input int n, input int p);
    return n - (beats_of(n, p) - 1) * p;
  endfunction

endpackage

// File: rtl/dot_product_feeder_lane_mask.sv
// Zeroes lanes when no data is present, and lanes at or beyond TAIL on the final beat.
module lane_mask #(
  parameter int LANES = 4,
  parameter int W     = 10,
  parameter int TAIL  = 4
) (
  input  logic [LANES*W-1:0] data,
  input  logic               en,
  input  logic               last,
  output logic [LANES*W-1:0] masked
);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    if (j >= TAIL) begin : g_tail
      assign masked[j*W +: W] = (en && !last) ? data[j*W +: W] : '0;
    end else begin : g_live
      assign masked[j*W +: W] = en ? data[j*W +: W] : '0;
    end
  end

endmodule

// File: rtl/dot_product_feeder.sv
// Streams PIXEL_N pixel/weight pairs from word-wide memory to a dot-product
// consumer, PARALLEL lanes per beat, followed by DRAIN all-zero cycles.
module dot_product_feeder
  import dot_product_feeder_pkg::*;
#(
  parameter int PIXEL_N     = 785,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int PARALLEL    = 4,
  parameter int DRAIN       = 30,
  parameter int ADDR_W      = 8
) (
  input  logic                            clk,
  input  logic                            GlobalReset,
  input  logic                            start,
  output logic                            rd_en,
  output logic [ADDR_W-1:0]               rd_addr,
  input  logic [PARALLEL*PIXEL_SIZE-1:0]  rd_pixels,
  input  logic [PARALLEL*WEIGHT_SIZE-1:0] rd_weights,
  output logic [PARALLEL*PIXEL_SIZE-1:0]  Pixels,
  output logic [PARALLEL*WEIGHT_SIZE-1:0] Weights,
  output logic                            out_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int BEATS = beats_of(PIXEL_N, PARALLEL);
  localparam int TAIL  = tail_of(PIXEL_N, PARALLEL);
  localparam int DW    = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BEATS - 1);
  localparam logic [DW-1:0]     DRAIN_END = DW'(DRAIN - 1);

  state_t                            state;
  logic [DW-1:0]                     drain_cnt;
  logic                              flush_cnt;
  // rd_vld/rd_last mark the cycle the memory word is on the bus; reset clears
  // them so words still in flight from an aborted stream are dropped.
  logic                              rd_vld;
  logic                              rd_last;
  logic [PARALLEL*PIXEL_SIZE-1:0]    pix_m;
  logic [PARALLEL*WEIGHT_SIZE-1:0]   wt_m;

  lane_mask #(.LANES(PARALLEL), .W(PIXEL_SIZE), .TAIL(TAIL)) u_pix_mask (
    .data(rd_pixels), .en(rd_vld), .last(rd_last), .masked(pix_m)
  );

  lane_mask #(.LANES(PARALLEL), .W(WEIGHT_SIZE), .TAIL(TAIL)) u_wt_mask (
    .data(rd_weights), .en(rd_vld), .last(rd_last), .masked(wt_m)
  );

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state     <= ST_IDLE;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      drain_cnt <= '0;
      flush_cnt <= 1'b0;
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
      Pixels    <= '0;
      Weights   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_vld    <= rd_en;
      rd_last   <= rd_en && (rd_addr == LAST_ADDR);
      Pixels    <= pix_m;
      Weights   <= wt_m;
      out_valid <= rd_vld;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_STREAM;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        ST_STREAM: begin
          // rd_addr saturates at the last word rather than wrapping
          if (rd_addr == LAST_ADDR) begin
            rd_en     <= 1'b0;
            flush_cnt <= 1'b0;
            state     <= ST_FLUSH;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt) begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_END) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          rd_addr <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
